// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch constants and the fetch output record.
package cpu_pkg;

    localparam int XLEN = 32;

    // Encoding that stops the fetch stage when it is read from the ROM.
    localparam logic [XLEN-1:0] DEFAULT_HALT_INSTR = 32'hffff_ffff;

    // Byte distance between consecutive instruction words.
    localparam logic [XLEN-1:0] PC_INC = 32'd4;

    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
    } fetch_out_t;

    // True when the byte PC addresses a word beyond a ROM of 2^addr_w words.
    function automatic logic pc_out_of_range(input logic [XLEN-1:0] pc,
                                             input int unsigned     addr_w);
        return (pc >> (addr_w + 2)) != '0;
    endfunction

endpackage

// File: rtl/pc_reg.sv
// Program counter register with redirect / increment / hold next-PC selection.
module pc_reg
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    input  logic            advance_i,
    output logic [XLEN-1:0] pc_o
);

    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pc_d;

    // Redirect wins over sequential advance; the target is forced word aligned.
    always_comb begin
        pc_d = pc_q;
        if (redirect_valid_i) begin
            pc_d = redirect_pc_i & ~(XLEN'(3));
        end else if (advance_i) begin
            pc_d = pc_q + PC_INC;
        end
    end

    // PC state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/instr_fetch.sv
// Fetch stage: addresses the combinational ROM, registers instruction+PC, and
// hands them to decode over valid/ready. Stops on a halt word or an
// out-of-range PC until redirected, and counts delivered instructions.
module instr_fetch
    import cpu_pkg::*;
#(
    parameter int              ADDR_W     = 5,
    parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
    parameter logic [XLEN-1:0] HALT_INSTR = DEFAULT_HALT_INSTR,
    parameter int              CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [XLEN-1:0]  rom_instr,
    input  logic             redirect_valid,
    input  logic [XLEN-1:0]  redirect_pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_instr,
    output logic [XLEN-1:0]  out_pc,
    output logic             halted,
    output logic             fault,
    output logic [CNT_W-1:0] fetch_count
);

    logic [XLEN-1:0] pc;

    fetch_out_t      out_q;
    fetch_out_t      out_d;
    logic            out_valid_q;
    logic            out_valid_d;
    logic            halted_q;
    logic            halted_d;
    logic            fault_q;
    logic            fault_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    logic out_free;
    logic fetch_en;
    logic pc_oor;
    logic is_halt;
    logic fetch_ok;
    logic fetch_stop;
    logic handshake;

    // The PC only advances when a real instruction is captured.
    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk              (clk),
        .rst_n            (rst_n),
        .redirect_valid_i (redirect_valid),
        .redirect_pc_i    (redirect_pc),
        .advance_i        (fetch_ok),
        .pc_o             (pc)
    );

    // Upper PC bits are dropped here; pc_oor decides whether the word is usable.
    assign rom_addr = pc[ADDR_W+1:2];

    // Fetch qualification and next-state for output register, halt/fault and counter.
    always_comb begin
        out_free   = !out_valid_q || out_ready;
        fetch_en   = out_free && !halted_q && !redirect_valid;
        pc_oor     = pc_out_of_range(pc, ADDR_W);
        is_halt    = (rom_instr == HALT_INSTR);
        fetch_ok   = fetch_en && !pc_oor && !is_halt;
        fetch_stop = fetch_en && (pc_oor || is_halt);
        handshake  = out_valid_q && out_ready;

        out_d       = out_q;
        out_valid_d = out_valid_q;
        halted_d    = halted_q;
        fault_d     = fault_q;
        cnt_d       = cnt_q;

        if (redirect_valid) begin
            // Flush after any handshake completing in this same cycle.
            out_valid_d = 1'b0;
            halted_d    = 1'b0;
            fault_d     = 1'b0;
        end else if (fetch_ok) begin
            out_d.instr = rom_instr;
            out_d.pc    = pc;
            out_valid_d = 1'b1;
        end else begin
            if (handshake) begin
                out_valid_d = 1'b0;
            end
            if (fetch_stop) begin
                halted_d = 1'b1;
                fault_d  = pc_oor;
            end
        end

        if (handshake && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    // Output register, sticky status flags and delivered-instruction counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q       <= '0;
            out_valid_q <= 1'b0;
            halted_q    <= 1'b0;
            fault_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
            halted_q    <= halted_d;
            fault_q     <= fault_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid   = out_valid_q;
    assign out_instr   = out_q.instr;
    assign out_pc      = out_q.pc;
    assign halted      = halted_q;
    assign fault       = fault_q;
    assign fetch_count = cnt_q;

endmodule
